// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared types and constants for the RaveNoC router output allocation
package ravenoc_pkg;

    localparam int NOC_IN_PORTS = 5;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/ravenoc_rr_picker.sv
// ravenoc_rr_picker: round-robin winner among a candidate mask, starting after last
module ravenoc_rr_picker
    import ravenoc_pkg::*;
#(
    parameter int N_INPUTS = NOC_IN_PORTS,
    parameter int IDX_W    = $clog2(N_INPUTS)
) (
    input  logic [N_INPUTS-1:0] mask,
    input  logic [IDX_W-1:0]    last,
    output logic [IDX_W-1:0]    winner,
    output logic                any
);

    logic [IDX_W-1:0]      start;
    logic [2*N_INPUTS-1:0] dbl;
    logic [N_INPUTS-1:0]   rot;
    logic [IDX_W-1:0]      pos;
    logic [IDX_W:0]        sum;

    // Rotation start wraps explicitly since N_INPUTS need not be a power of two
    assign start = (last == IDX_W'(N_INPUTS - 1)) ? '0 : last + 1'b1;
    assign dbl   = {mask, mask} >> start;
    assign rot   = dbl[N_INPUTS-1:0];

    // Priority-encode the lowest set bit of the rotated mask
    always_comb begin
        pos = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) pos = rot[i] ? IDX_W'(i) : pos;
    end

    // Un-rotate: add the start offset back and wrap modulo N_INPUTS
    assign sum    = {1'b0, pos} + {1'b0, start};
    assign winner = IDX_W'((sum >= (IDX_W+1)'(N_INPUTS)) ? sum - (IDX_W+1)'(N_INPUTS) : sum);
    assign any    = |mask;

endmodule

// File: rtl/ravenoc_out_arbiter.sv
// ravenoc_out_arbiter: wormhole round-robin allocator for one router output port
module ravenoc_out_arbiter
    import ravenoc_pkg::*;
#(
    parameter int N_INPUTS = NOC_IN_PORTS,
    parameter int IDX_W    = $clog2(N_INPUTS)
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [N_INPUTS-1:0] req_i,
    input  logic [N_INPUTS-1:0] head_i,
    input  logic [N_INPUTS-1:0] tail_i,
    input  logic                out_rdy_i,
    output logic [N_INPUTS-1:0] grant_o,
    output logic [IDX_W-1:0]    sel_o,
    output logic                out_vld_o,
    output logic                busy_o,
    output logic                err_o
);

    arb_state_t       state, next_state;
    logic [IDX_W-1:0] owner, last, winner;
    logic             err, fired, any, busy, fire, tail_fire, bad_body, dup_head;

    ravenoc_rr_picker #(.N_INPUTS(N_INPUTS), .IDX_W(IDX_W)) u_picker (
        .mask   (req_i & head_i),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    assign busy      = state == LOCKED;
    assign fire      = busy & req_i[owner] & out_rdy_i;
    assign tail_fire = fire & tail_i[owner];
    assign bad_body  = ~busy & |(req_i & ~head_i);
    assign dup_head  = busy & fired & req_i[owner] & head_i[owner];

    // State register; reset drops any lock immediately
    always_ff @(posedge clk) begin
        if (!arst) state <= IDLE;
        else       state <= next_state;
    end

    // Lock on any head candidate, release only after the owner's tail fires
    always_comb begin
        next_state = busy ? (tail_fire ? IDLE : LOCKED) : (any ? LOCKED : IDLE);
    end

    // Owner capture, round-robin pointer, first-fire tracking and sticky error
    always_ff @(posedge clk) begin
        if (!arst) begin
            owner <= '0;
            last  <= IDX_W'(N_INPUTS - 1);
            fired <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (!busy && any) begin
                owner <= winner;
                fired <= 1'b0;
            end
            if (fire)      fired <= 1'b1;
            if (tail_fire) last  <= owner;
            err <= err | bad_body | dup_head;
        end
    end

    // Outputs depend only on registered state, req_i and out_rdy_i
    always_comb begin
        grant_o   = (busy & out_rdy_i) ? (N_INPUTS'(1) << owner) & req_i : '0;
        out_vld_o = busy & req_i[owner];
        busy_o    = busy;
        sel_o     = owner;
        err_o     = err;
    end

endmodule

// File: doc/ravenoc_out_arbiter.md
# ravenoc_out_arbiter

Wormhole output-port allocator for one RaveNoC router output (north, south, west, east or local). Shares the output among the router's input ports with round-robin fairness and holds the grant from a packet's head flit through its tail flit. One instance per output port inside the router wrapper; it drives the crossbar select and the output-side valid.

## Interface
Parameters:
- `N_INPUTS`, 5: number of competing input ports (N, S, W, E, local).
- `IDX_W`, `$clog2(N_INPUTS)`: width of the owner index.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `arst`  in  1  reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `req_i`  in  N_INPUTS  input i holds a valid flit routed to this output.
- `head_i`  in  N_INPUTS  the flit at input i is a head flit.
- `tail_i`  in  N_INPUTS  the flit at input i is a tail flit. Head and tail both set means a single-flit packet.
- `out_rdy_i`  in  1  downstream can accept a flit this cycle.
- `grant_o`  out  N_INPUTS  one-hot grant; it also pops the flit from the owning input buffer when `fire` occurs.
- `sel_o`  out  IDX_W  crossbar select equal to the owner index. Valid only while `busy_o`.
- `out_vld_o`  out  1  a flit is presented downstream.
- `busy_o`  out  1  the output is locked to a packet.
- `err_o`  out  1  sticky protocol error.

## Operation
- Registered state:
  - FSM `state` ∈ {IDLE, LOCKED}.
  - `owner` [IDX_W].
  - round-robin pointer `last` [IDX_W], which holds the most recent owner.
  - `err`.
- IDLE:
  - The candidates are the inputs with `req_i[i] & head_i[i]`.
  - The winner is the first candidate scanning `last+1, last+2, …` modulo N_INPUTS.
  - If at least one candidate exists: `owner` ← winner and `state` ← LOCKED.
  - An input with `req_i` set and `head_i` clear in IDLE is not a candidate and sets `err`. It is never granted.
- LOCKED:
  - `fire = req_i[owner] & out_rdy_i`.
  - On `fire & tail_i[owner]`: `state` ← IDLE and `last` ← owner.
  - On `fire & ~tail_i[owner]`: stay in LOCKED.
  - On `req_i[owner]` low (source bubble) or `out_rdy_i` low: hold. There is no timeout and no preemption.
  - `head_i[owner]` seen again after the first fire of a packet sets `err`. The flit is still forwarded.
- Outputs:
  - `busy_o = (state==LOCKED)`.
  - `grant_o = busy_o & out_rdy_i ? onehot(owner) & req_i : 0`.
  - `out_vld_o = busy_o & req_i[owner]`.
  - `sel_o = owner`.
- `err` is cleared only by reset.
- Index arithmetic wraps modulo N_INPUTS, which need not be a power of two. The pointer never takes a value ≥ N_INPUTS.

## Timing
- Reset (`arst`=0 at an edge):
  - `state`=IDLE, `owner`=0, `last`=N_INPUTS-1 (so input 0 has first priority), `err`=0.
  - All outputs read 0.
  - Reset asserted mid-packet drops the lock immediately. Upstream and downstream recovery is their responsibility.
- Arbitration costs one bubble cycle per packet. A head flit presented in cycle t can fire at the earliest in cycle t+1.
- A tail fire in cycle t returns the FSM to IDLE in t+1. The next packet can fire in t+2.
- Throughput within a packet is 1 flit/cycle while `req_i[owner]` and `out_rdy_i` are both high.
- Simultaneous events:
  - A new head arriving at another input during LOCKED waits.
  - A tail fire coinciding with a new head on the same input: the released input becomes lowest priority at the next arbitration.
- All outputs are combinational from registered state plus `req_i` and `out_rdy_i`. There are no combinational paths from `head_i` or `tail_i` to the outputs.

## Structure
- In `ravenoc_pkg`:
  - `arb_state_t` enum {IDLE, LOCKED}.
  - a `NOC_IN_PORTS` constant = 5.
- Sub-module `ravenoc_rr_picker`: purely combinational.
  - Inputs: candidate mask, `last`.
  - Outputs: winner index and `any` flag.
  - Implemented by rotating the mask right by `last+1`, taking a priority-encode and un-rotating.
- FSM, pointer and error logic stay in the top module.

## Test plan
- Reset → all outputs 0. First contention with `req_i=5'b11111` and all heads set → owner 0 (`sel_o`=0) in the next cycle.
- Single-flit packet on input 2 (head=tail=1, `out_rdy_i`=1) → `out_vld_o` high exactly one cycle, one cycle after the request; `busy_o` low the following cycle.
- 3-flit packets pending on inputs 1 and 3 simultaneously → order 1,1,1 then 3,3,3; `grant_o` never 1 on input 3 until input 1's tail fires; one-cycle gap between packets.
- Inputs 0 and 4 continuously sending 1-flit packets with `last` starting at 4 → grants alternate 0,4,0,4; neither starves.
- Backpressure: `out_rdy_i`=0 for 4 cycles mid-packet → `grant_o`=0 during the stall, state stays LOCKED, owner unchanged, no flit lost.
- Body flit without head in IDLE → `err_o`=1 and stays 1. `arst` low during a 4-flit packet → IDLE next cycle, `err_o`=0.
